// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and registers the returned word with its PC+4 into the IF/ID pipeline register.
// Handles stall, branch/jump redirect with squash, misaligned-target flagging
// and a count of valid instructions delivered to ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        pc_oob,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    // One past the last valid byte address; 33 bits so 4*IMEM_WORDS cannot overflow.
    localparam logic [32:0] OobLimit = 33'(IMEM_WORDS) << 2;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign redirect = branch_taken | jump;
    // Branch is the older instruction, so its target wins over a jump.
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state selection: redirect > stall > normal sequential fetch.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        if (redirect) begin
            pc_d    = {target[31:2], 2'b00};
            instr_d = NOP;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            if (target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d    = pc_plus4;
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign pc_oob       = ({1'b0, pc_q} >= OobLimit);
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect traffic, compared against a cycle-level behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        pc_oob;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_mis;

    localparam logic [31:0] INS_A = 32'h2008_0001;
    localparam logic [31:0] INS_B = 32'h2009_0002;
    localparam logic [31:0] INS_C = 32'h012A_4020;
    localparam logic [31:0] INS_D = 32'hAC08_0000;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[11:2]];

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .pc_oob       (pc_oob),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic compare_all(input string tag);
        logic oob_exp;
        oob_exp = (longint'(m_pc) >= 64'd4 * 64'd1024);
        check({tag, ".addr"},  imem_addr, m_pc);
        check({tag, ".instr"}, if_id_instr, m_instr);
        check({tag, ".pc4"},   if_id_pc4, m_pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({tag, ".oob"},   {31'd0, pc_oob}, {31'd0, oob_exp});
        check({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, m_mis});
        check({tag, ".cnt"},   fetch_count, m_cnt);
    endtask

    // Drive one cycle's inputs, advance the model by the fetch rules, then compare.
    task automatic cycle(input string tag, input logic s, input logic b, input logic j,
                         input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] tgt;
        stall = s; branch_taken = b; jump = j; branch_target = bt; jump_target = jt;
        if (b || j) begin
            tgt = b ? bt : jt;
            if (tgt % 4 != 0) m_mis = 1'b1;
            m_pc    = tgt - (tgt % 4);
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = mem[(m_pc / 4) % 1024];
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        stall = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        if ($urandom_range(0, 5) == 0) t = $urandom;
        else t = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        reset = 1'b1;
        stall = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = INS_A; mem[1] = INS_B; mem[2] = INS_C; mem[3] = INS_D;

        // Free-running fetch of A..D.
        do_reset();
        cycle("run0", 0, 0, 0, 0, 0);
        check("run0.A", if_id_instr, INS_A);
        cycle("run1", 0, 0, 0, 0, 0);
        cycle("run2", 0, 0, 0, 0, 0);
        cycle("run3", 0, 0, 0, 0, 0);
        check("run3.D", if_id_instr, INS_D);
        check("run3.pc4", if_id_pc4, 32'd16);
        check("run3.cnt", fetch_count, 32'd4);

        // Stall at pc = 8.
        do_reset();
        cycle("pre0", 0, 0, 0, 0, 0);
        cycle("pre1", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("stall", 1, 0, 0, 0, 0);
        check("stall.addr", imem_addr, 32'd8);
        check("stall.B", if_id_instr, INS_B);
        check("stall.cnt", fetch_count, 32'd2);
        cycle("release", 0, 0, 0, 0, 0);
        check("release.C", if_id_instr, INS_C);
        check("release.pc4", if_id_pc4, 32'd12);

        // Branch and jump together: branch wins.
        cycle("brjmp", 0, 1, 1, 32'h40, 32'h80);
        check("brjmp.addr", imem_addr, 32'h40);
        check("brjmp.valid", {31'd0, if_id_valid}, 32'd0);
        cycle("brjmp1", 0, 0, 0, 0, 0);
        check("brjmp1.instr", if_id_instr, mem[16]);
        check("brjmp1.pc4", if_id_pc4, 32'h44);

        // Misaligned jump while stalled; flag is sticky.
        cycle("misj", 1, 0, 1, 0, 32'h23);
        check("misj.addr", imem_addr, 32'h20);
        check("misj.mis", {31'd0, misalign_err}, 32'd1);
        for (int i = 0; i < 10; i++) cycle("mis_hold", 0, 0, 0, 0, 0);
        check("mis_hold.mis", {31'd0, misalign_err}, 32'd1);

        // Out-of-range boundary and 32-bit wrap.
        cycle("to_ff8", 0, 0, 1, 0, 32'hFF8);
        cycle("at_ffc", 0, 0, 0, 0, 0);
        check("ffc.oob", {31'd0, pc_oob}, 32'd0);
        cycle("at_1000", 0, 0, 0, 0, 0);
        check("1000.addr", imem_addr, 32'h1000);
        check("1000.oob", {31'd0, pc_oob}, 32'd1);
        cycle("to_top", 0, 0, 1, 0, 32'hFFFF_FFFC);
        cycle("wrap", 0, 0, 0, 0, 0);
        check("wrap.addr", imem_addr, 32'h0);

        // Asynchronous reset mid-cycle during a redirect.
        for (int i = 0; i < 3; i++) cycle("pre_rst", 0, 0, 0, 0, 0);
        branch_taken = 1; branch_target = 32'h100; jump = 1; jump_target = 32'h201;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        branch_taken = 0; jump = 0;

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic s, b, j;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            j = ($urandom_range(0, 9) == 0);
            cycle("rand", s, b, j, rand_target(), rand_target());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
